// File: rtl/avmem_pkg.sv
// Shared constants and types for the Avalon-MM responder memory model.
// The optional irq register bank is enabled by defining AVMEM_IRQ_EN.
package avmem_pkg;

  localparam int unsigned AV_ADDRWIDTH  = 32;
  localparam int unsigned AV_DATAWIDTH  = 32;
  localparam int unsigned NUM_LANES     = AV_DATAWIDTH / 8;

  localparam int unsigned DEF_MEMDEPTH  = 12;
  localparam int unsigned DEF_RDLATENCY = 2;
  localparam int unsigned DEF_IRQWIDTH  = 32;

  // Address bit that selects the register space over RAM.
  localparam int unsigned SPACE_SEL_BIT = AV_ADDRWIDTH - 1;

  localparam logic [AV_ADDRWIDTH-1:0] IRQSET_OFS = 32'h0000_0000;
  localparam logic [AV_ADDRWIDTH-1:0] IRQCLR_OFS = 32'h0000_0004;

  typedef struct packed {
    logic                    vld;
    logic [AV_DATAWIDTH-1:0] data;
  } rd_beat_t;

  // Expand per-lane byte enables into a bit mask over the data word.
  function automatic logic [AV_DATAWIDTH-1:0] lane_mask(input logic [NUM_LANES-1:0] be);
    logic [AV_DATAWIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/avmem_rdpipe.sv
// Read response delay line: DEPTH stages of valid+data; stage 0 captures the
// RAM/register read mux. Data of each stage only moves with a valid beat.
module avmem_rdpipe
  import avmem_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_RDLATENCY
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    in_vld,
  input  logic [AV_DATAWIDTH-1:0] in_data,
  output logic                    out_vld,
  output logic [AV_DATAWIDTH-1:0] out_data
);

  rd_beat_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0].vld <= in_vld;
      if (in_vld) begin
        stage[0].data <= in_data;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage[i].vld <= stage[i-1].vld;
        if (stage[i-1].vld) begin
          stage[i].data <= stage[i-1].data;
        end
      end
    end
  end

  assign out_vld  = stage[DEPTH-1].vld;
  assign out_data = stage[DEPTH-1].data;

endmodule

// File: rtl/avmem_responder.sv
// Avalon-MM responder memory model with fixed-latency pipelined reads.
// Define AVMEM_IRQ_EN to map an IRQSET/IRQCLR register bank at address bit 31.
module avmem_responder
  import avmem_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = AV_ADDRWIDTH,
  parameter int unsigned DATAWIDTH = AV_DATAWIDTH,
  parameter int unsigned MEMDEPTH  = DEF_MEMDEPTH,
  parameter int unsigned RDLATENCY = DEF_RDLATENCY,
  parameter int unsigned IRQWIDTH  = DEF_IRQWIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDRWIDTH-1:0]   av_address,
  input  logic [DATAWIDTH/8-1:0] av_byteenable,
  input  logic                   av_write,
  input  logic [DATAWIDTH-1:0]   av_writedata,
  input  logic                   av_read,
  output logic [DATAWIDTH-1:0]   av_readdata,
  output logic                   av_readdatavalid,
  output logic [IRQWIDTH-1:0]    irq,
  output logic                   protocol_err
);

  localparam int unsigned WORDS = 1 << MEMDEPTH;

  logic [DATAWIDTH-1:0] mem [WORDS];
  logic [MEMDEPTH-1:0]  word_idx;
  logic                 reg_sel;
  logic                 rd_accept;
  logic [DATAWIDTH-1:0] reg_rdata;
  logic [DATAWIDTH-1:0] rd_mux;
  logic                 unused_addr;

  // Upper address bits wrap the memory; byte offset bits are don't-care.
  assign word_idx    = av_address[MEMDEPTH+1:2];
  assign unused_addr = ^{av_address[ADDRWIDTH-1:MEMDEPTH+2], av_address[1:0]};

  // A read colliding with a write is dropped; the write still lands.
  assign rd_accept = av_read & ~av_write & ~reset;

`ifdef AVMEM_IRQ_EN
  logic [IRQWIDTH-1:0]  irq_q;
  logic [DATAWIDTH-1:0] wr_bits;
  logic                 hit_set;
  logic                 hit_clr;

  assign reg_sel = av_address[SPACE_SEL_BIT];
  assign hit_set = reg_sel && (av_address[SPACE_SEL_BIT-1:2] == IRQSET_OFS[SPACE_SEL_BIT-1:2]);
  assign hit_clr = reg_sel && (av_address[SPACE_SEL_BIT-1:2] == IRQCLR_OFS[SPACE_SEL_BIT-1:2]);
  assign wr_bits = av_writedata & lane_mask(av_byteenable);

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= '0;
    end else if (av_write && hit_set) begin
      irq_q <= irq_q | IRQWIDTH'(wr_bits);
    end else if (av_write && hit_clr) begin
      irq_q <= irq_q & ~IRQWIDTH'(wr_bits);
    end
  end

  always_comb begin
    reg_rdata = '0;
    if (hit_set) begin
      reg_rdata = DATAWIDTH'(irq_q);
    end
  end

  assign irq = irq_q;
`else
  assign reg_sel   = 1'b0;
  assign reg_rdata = '0;
  assign irq       = '0;
`endif

  // Byte-enabled RAM write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (av_write && !reg_sel) begin
      for (int i = 0; i < int'(DATAWIDTH/8); i++) begin
        if (av_byteenable[i]) begin
          mem[word_idx][8*i +: 8] <= av_writedata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_mux = mem[word_idx];
    if (reg_sel) begin
      rd_mux = reg_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      protocol_err <= 1'b0;
    end else if (av_read && av_write) begin
      protocol_err <= 1'b1;
    end
  end

  avmem_rdpipe #(
    .DEPTH (RDLATENCY)
  ) u_rdpipe (
    .clk      (clk),
    .clear    (reset),
    .in_vld   (rd_accept),
    .in_data  (rd_mux),
    .out_vld  (av_readdatavalid),
    .out_data (av_readdata)
  );

endmodule

// File: tb/tb_avmem_responder.sv
// Directed self-checking bench for avmem_responder (MEMDEPTH=4, RDLATENCY=2).
// Expectations for the irq bank follow whether AVMEM_IRQ_EN is defined.
module tb_avmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] av_address;
  logic [3:0]  av_byteenable;
  logic        av_write;
  logic [31:0] av_writedata;
  logic        av_read;
  logic [31:0] av_readdata;
  logic        av_readdatavalid;
  logic [31:0] irq;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  avmem_responder #(
    .MEMDEPTH  (4),
    .RDLATENCY (2),
    .IRQWIDTH  (32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .av_address       (av_address),
    .av_byteenable    (av_byteenable),
    .av_write         (av_write),
    .av_writedata     (av_writedata),
    .av_read          (av_read),
    .av_readdata      (av_readdata),
    .av_readdatavalid (av_readdatavalid),
    .irq              (irq),
    .protocol_err     (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    @(negedge clk);
    av_write = 1'b0;
    av_read  = 1'b0;
  endtask

  task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    av_read       = 1'b0;
    av_write      = 1'b1;
    av_address    = a;
    av_writedata  = d;
    av_byteenable = be;
  endtask

  // Issue one read; lat is negedges until valid (-1 if it never arrives).
  task automatic read_word(input logic [31:0] a, output logic [31:0] d, output int lat);
    bit seen;
    @(negedge clk);
    av_write   = 1'b0;
    av_read    = 1'b1;
    av_address = a;
    lat  = -1;
    d    = 'x;
    seen = 1'b0;
    for (int i = 1; i <= 10 && !seen; i++) begin
      @(negedge clk);
      av_read = 1'b0;
      if (av_readdatavalid) begin
        lat  = i;
        d    = av_readdata;
        seen = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (av_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp %h", av_readdata, 32'h0); end
    checks++; if (av_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", av_readdatavalid); end
    checks++; if (irq !== 32'h0) begin errors++; $display("FAIL reset_irq got %h exp 0", irq); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", protocol_err); end
  endtask

  task automatic test_write_read();
    logic [31:0] d;
    int lat;
    write_word(32'h10, 32'hDEADBEEF, 4'hF);
    read_word(32'h10, d, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL wr_rd_latency got %0d exp 2", lat); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data got %h exp DEADBEEF", d); end
  endtask

  task automatic test_byteenable();
    logic [31:0] d;
    int lat;
    write_word(32'h20, 32'h11223344, 4'hF);
    write_word(32'h20, 32'hAABBCCDD, 4'h5);
    read_word(32'h20, d, lat);
    checks++; if (d !== 32'h11BB33DD) begin errors++; $display("FAIL be_merge got %h exp 11BB33DD", d); end
    write_word(32'h20, 32'hFFFFFFFF, 4'h0);
    read_word(32'h20, d, lat);
    checks++; if (d !== 32'h11BB33DD) begin errors++; $display("FAIL be_zero_noop got %h exp 11BB33DD", d); end
  endtask

  task automatic test_back_to_back();
    logic        v [7];
    logic [31:0] dd [7];
    for (int i = 0; i < 4; i++) write_word(32'(4*i), 32'(i+1), 4'hF);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      v[c]  = av_readdatavalid;
      dd[c] = av_readdata;
      av_write   = 1'b0;
      av_read    = (c < 4);
      av_address = 32'(4*c);
    end
    av_read = 1'b0;
    for (int c = 1; c < 7; c++) begin
      checks++;
      if (v[c] !== (c >= 2 && c <= 5)) begin
        errors++; $display("FAIL b2b_valid c%0d got %b exp %b", c, v[c], (c >= 2 && c <= 5));
      end
    end
    for (int c = 2; c < 7; c++) begin
      checks++;
      if (dd[c] !== 32'((c <= 5) ? c - 1 : 4)) begin
        errors++; $display("FAIL b2b_data c%0d got %h exp %h", c, dd[c], 32'((c <= 5) ? c - 1 : 4));
      end
    end
  endtask

  task automatic test_alias();
    logic [31:0] d;
    int lat;
    write_word(32'h40, 32'h55, 4'hF);
    read_word(32'h0, d, lat);
    checks++; if (d !== 32'h55) begin errors++; $display("FAIL alias_wrap got %h exp 55", d); end
    read_word(32'h3, d, lat);
    checks++; if (d !== 32'h55) begin errors++; $display("FAIL alias_lowbits got %h exp 55", d); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL alias_latency got %0d exp 2", lat); end
  endtask

  task automatic test_protocol_err();
    logic [31:0] d;
    int lat;
    @(negedge clk);
    av_read = 1'b1; av_write = 1'b1; av_address = 32'h8;
    av_writedata = 32'h7; av_byteenable = 4'hF;
    for (int c = 0; c < 4; c++) begin
      idle();
      checks++; if (av_readdatavalid !== 1'b0) begin errors++; $display("FAIL collide_valid c%0d got %b exp 0", c, av_readdatavalid); end
      checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_sticky c%0d got %b exp 1", c, protocol_err); end
    end
    read_word(32'h8, d, lat);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL collide_write got %h exp 7", d); end
    // Reset while a read is in flight.
    @(negedge clk);
    av_read = 1'b1; av_address = 32'h8;
    @(negedge clk);
    av_read = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (av_readdatavalid !== 1'b0) begin errors++; $display("FAIL midreset_valid c%0d got %b exp 0", c, av_readdatavalid); end
      @(negedge clk);
    end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL midreset_perr got %b exp 0", protocol_err); end
    checks++; if (av_readdata !== 32'h0) begin errors++; $display("FAIL midreset_rdata got %h exp 0", av_readdata); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    int lat;
    logic [31:0] exp_irq1, exp_irq2, exp_rd_set, exp_rd_clr, exp_ram0;
`ifdef AVMEM_IRQ_EN
    exp_irq1 = 32'h5; exp_irq2 = 32'h4; exp_rd_set = 32'h4; exp_rd_clr = 32'h0; exp_ram0 = 32'h55;
`else
    exp_irq1 = 32'h0; exp_irq2 = 32'h0; exp_rd_set = 32'h5; exp_rd_clr = 32'h1; exp_ram0 = 32'h5;
`endif
    write_word(32'h8000_0000, 32'h0000_0005, 4'hF);
    idle();
    checks++; if (irq !== exp_irq1) begin errors++; $display("FAIL irq_set got %h exp %h", irq, exp_irq1); end
    write_word(32'h8000_0004, 32'h0000_0001, 4'hF);
    idle();
    checks++; if (irq !== exp_irq2) begin errors++; $display("FAIL irq_clr got %h exp %h", irq, exp_irq2); end
    read_word(32'h8000_0000, d, lat);
    checks++; if (d !== exp_rd_set) begin errors++; $display("FAIL irq_rd_set got %h exp %h", d, exp_rd_set); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL irq_rd_latency got %0d exp 2", lat); end
    read_word(32'h8000_0004, d, lat);
    checks++; if (d !== exp_rd_clr) begin errors++; $display("FAIL irq_rd_clr got %h exp %h", d, exp_rd_clr); end
    read_word(32'h0, d, lat);
    checks++; if (d !== exp_ram0) begin errors++; $display("FAIL irq_ram_word0 got %h exp %h", d, exp_ram0); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    av_address    = '0;
    av_byteenable = '0;
    av_write      = 1'b0;
    av_writedata  = '0;
    av_read       = 1'b0;
    test_reset();
    test_write_read();
    test_byteenable();
    test_back_to_back();
    test_alias();
    test_protocol_err();
    test_irq();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
